temporizador_fim: RTL and testbench
===================================

# temporizador_fim

Parametrised end-of-transaction timer for the vending machine. It watches N end-of-sale events such as liberar produto and devolver moeda. After a programmable number of 1-second ticks it emits a FIM pulse of programmable width. It runs on the system clock with a tick enable, so no divided clock is needed, and it supports retrigger, cancel and cause reporting.

## Interface
- N_EVT, 2: number of event inputs (≥1); bit 0 = LP, bit 1 = DM by convention
- ATRASO, 4: ticks between trigger and FIM (≥1)
- LARG_PULSO, 1: FIM width in clk cycles (≥1)
- RETRIG, 0: 1 = a new event during the count reloads the count; 0 = it is ignored
- LARG_CNT, $clog2(ATRASO+1): derived width of `restante`, not overridden
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk-wide 1-second enable
- evt  in  N_EVT  event levels; rising edges trigger
- cancela  in  1  abort the current timing with no FIM
- FIM  out  1  end pulse, registered
- ocupado  out  1  high in CONTANDO and PULSO
- causa  out  N_EVT  events that contributed to the current timing
- restante  out  LARG_CNT  ticks left

## Operation
- **Edge detection**
  - `evt_d` is registered every clk and is not gated by `tick`; `evt_d` resets to 0.
  - `sobe = evt & ~evt_d`.
  - A level already high at reset release therefore counts as an event.
- **OCIOSO**
  - Outputs: FIM=0, ocupado=0, restante=0, causa=0.
  - Any `sobe` bit → CONTANDO, with restante=ATRASO and causa=`sobe` (all simultaneous bits).
- **CONTANDO**
  - On `tick`: restante−1.
  - On `tick` with restante==1 → PULSO, restante=0, pulse counter=LARG_PULSO.
  - `sobe` with RETRIG=1: restante=ATRASO and causa |= `sobe`. Reload wins over a same-cycle tick.
  - `sobe` with RETRIG=0: ignored; causa unchanged.
- **PULSO**
  - FIM=1 for exactly LARG_PULSO clk cycles, counted in clk cycles, not ticks.
  - causa holds during the pulse.
  - Then → OCIOSO and causa clears.
  - `sobe` during PULSO is dropped; it is not queued.
- **cancela** has the highest priority in any state: next cycle is OCIOSO, with FIM=0, causa=0, restante=0.
- **rst** overrides everything, including mid-count or mid-pulse; all outputs return to reset values on the next edge.
- **Reset values**: state OCIOSO, FIM 0, ocupado 0, causa 0, restante 0, `evt_d` 0.

## Timing
- A `sobe` in cycle k gives ocupado=1 and restante=ATRASO from cycle k+1.
- A tick in cycle k is not counted; counting starts with ticks at cycle ≥ k+1.
- FIM rises on the clk edge after the ATRASO-th counted tick.
- FIM falls LARG_PULSO cycles after it rises; ocupado falls in the same cycle.
- With cancela in cycle c, all outputs are at idle values from c+1.
- Back-to-back transactions:
  - A rise in the first OCIOSO cycle after PULSO is accepted.
  - The minimum gap between FIM pulses is ATRASO ticks + 1 clk.
- Every output is a flop output; there is no combinational path from input to output.

## Structure
- Shared package `maquina_pkg` (also used by other vending-machine blocks) holds:
  - state encodings OCIOSO=2'd0, CONTANDO=2'd1, PULSO=2'd2;
  - the event bit indices EVT_LP=0, EVT_DM=1.
- Sub-module `detector_borda` (parameter LARG):
  - contents: the registered `evt_d` plus the `sobe` logic;
  - reset: synchronous;
  - reuse: also used by the coin-input path.
- Top level: one FSM, the `restante` down-counter, the pulse counter and the `causa` register.

## Test plan
- **Basic timing.** Defaults, tick every 10 clk. evt=2'b01 rises at clk 3. Expected:
  - causa=01 and ocupado=1 from clk 4;
  - restante counts 4,3,2,1,0;
  - FIM=1 for one clk, right after the 4th tick;
  - then everything idle.
- **Simultaneous events.** evt=2'b11 rises in one cycle → causa=11; a single FIM pulse.
- **RETRIG=0.** Rise LP, then rise DM with restante=2 → DM ignored; FIM after 4 ticks from LP; causa=01.
- **RETRIG=1, same sequence.** restante reloads to 4; causa=11; FIM after 4 ticks from the DM rise.
- **Reload versus tick.** RETRIG=1, DM rise and tick in the same cycle → restante=4, not 3.
- **Cancel, reset, pulse width, early event.**
  - cancela with restante=1 → no FIM, causa=0 next cycle.
  - rst asserted mid-PULSO with LARG_PULSO=3 → FIM=0 next cycle.
  - evt held high through reset release → timing starts on the first cycle after rst falls.

Source files
------------

// File: rtl/maquina_pkg.sv
// ---------------------------------------------------------------------------
// maquina_pkg
// Definitions shared by the vending-machine blocks.
//   estado_t : state encoding of the end-of-transaction timer FSM
//   EVT_LP   : event bit for "liberar produto" (product released)
//   EVT_DM   : event bit for "devolver moeda" (coin returned)
// ---------------------------------------------------------------------------
package maquina_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    PULSO    = 2'd2
  } estado_t;

  localparam int EVT_LP = 0;
  localparam int EVT_DM = 1;

endpackage : maquina_pkg

// File: rtl/temporizador_fim_if.sv
// ---------------------------------------------------------------------------
// temporizador_fim_if
// Bundles the control and status signals of the end-of-transaction timer.
//   tick     : one-clk-wide 1-second enable
//   evt      : end-of-sale event levels (rising edges trigger)
//   cancela  : abort current timing, no FIM
//   FIM      : end pulse
//   ocupado  : timer counting or pulsing
//   causa    : events that contributed to the current timing
//   restante : ticks left
// master = stimulus side, slave = timer side.
// ---------------------------------------------------------------------------
interface temporizador_fim_if #(
  parameter int N_EVT    = 2,
  parameter int LARG_CNT = 3
);
  import maquina_pkg::*;

  logic                tick;
  logic [N_EVT-1:0]    evt;
  logic                cancela;
  logic                FIM;
  logic                ocupado;
  logic [N_EVT-1:0]    causa;
  logic [LARG_CNT-1:0] restante;

  modport master (
    output tick, evt, cancela,
    input  FIM, ocupado, causa, restante
  );

  modport slave (
    input  tick, evt, cancela,
    output FIM, ocupado, causa, restante
  );

endinterface : temporizador_fim_if

// File: rtl/detector_borda.sv
// ---------------------------------------------------------------------------
// detector_borda
// Rising-edge detector for a vector of levels. The delayed copy is updated
// every clk and clears on reset, so a level already high when reset is
// released is reported as a rising edge.
//   clk     : system clock
//   rst     : synchronous, active-high reset
//   i_nivel : input levels
//   o_sobe  : one-clk rising-edge flags (combinational from i_nivel)
// ---------------------------------------------------------------------------
module detector_borda #(
  parameter int LARG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LARG-1:0] i_nivel,
  output logic [LARG-1:0] o_sobe
);

  logic [LARG-1:0] r_nivel_d;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_nivel_d <= '0;
    else     r_nivel_d <= i_nivel;
  end

  assign o_sobe = i_nivel & ~r_nivel_d;

endmodule : detector_borda

// File: rtl/temporizador_fim.sv
// ---------------------------------------------------------------------------
// temporizador_fim
// End-of-transaction timer. A rising edge on any event starts a count of
// ATRASO ticks; when it expires FIM is pulsed for LARG_PULSO clk cycles.
// Supports retrigger (RETRIG), cancel and cause reporting.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : temporizador_fim_if.slave (tick, evt, cancela in;
//          FIM, ocupado, causa, restante out - all registered)
// ---------------------------------------------------------------------------
module temporizador_fim
  import maquina_pkg::*;
#(
  parameter int N_EVT      = 2,
  parameter int ATRASO     = 4,
  parameter int LARG_PULSO = 1,
  parameter bit RETRIG     = 1'b0,
  parameter int LARG_CNT   = $clog2(ATRASO + 1)
) (
  input  logic                clk,
  input  logic                rst,
  temporizador_fim_if.slave   bus
);

  localparam int LARG_PC = $clog2(LARG_PULSO + 1);
  localparam logic [LARG_CNT-1:0] RECARGA   = LARG_CNT'(ATRASO);
  localparam logic [LARG_PC-1:0]  PULSO_INI = LARG_PC'(LARG_PULSO);

  estado_t             r_estado, w_prox;
  logic [LARG_CNT-1:0] r_restante, w_restante;
  logic [N_EVT-1:0]    r_causa, w_causa;
  logic [LARG_PC-1:0]  r_pulso, w_pulso;
  logic                r_fim;
  logic                r_ocupado;
  logic [N_EVT-1:0]    w_sobe;

  detector_borda #(.LARG(N_EVT)) u_borda (
    .clk     (clk),
    .rst     (rst),
    .i_nivel (bus.evt),
    .o_sobe  (w_sobe)
  );

  // NOTE: every signal gets a default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    w_prox     = r_estado;
    w_restante = r_restante;
    w_causa    = r_causa;
    w_pulso    = r_pulso;

    if (bus.cancela) begin
      w_prox     = OCIOSO;
      w_restante = '0;
      w_causa    = '0;
      w_pulso    = '0;
    end else begin
      unique case (r_estado)
        OCIOSO: begin
          // A tick in the trigger cycle is deliberately not counted.
          if (|w_sobe) begin
            w_prox     = CONTANDO;
            w_restante = RECARGA;
            w_causa    = w_sobe;
          end
        end
        CONTANDO: begin
          // Reload takes precedence over a tick in the same cycle.
          if (RETRIG && (|w_sobe)) begin
            w_restante = RECARGA;
            w_causa    = r_causa | w_sobe;
          end else if (bus.tick) begin
            if (r_restante == LARG_CNT'(1)) begin
              w_prox     = PULSO;
              w_restante = '0;
              w_pulso    = PULSO_INI;
            end else begin
              w_restante = r_restante - LARG_CNT'(1);
            end
          end
        end
        PULSO: begin
          // Width counted in clk cycles; events arriving now are dropped.
          if (r_pulso == LARG_PC'(1)) begin
            w_prox  = OCIOSO;
            w_causa = '0;
            w_pulso = '0;
          end else begin
            w_pulso = r_pulso - LARG_PC'(1);
          end
        end
        default: begin
          w_prox     = OCIOSO;
          w_restante = '0;
          w_causa    = '0;
          w_pulso    = '0;
        end
      endcase
    end
  end

  // FIM and ocupado are decoded from the next state so they leave flops
  // aligned with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= OCIOSO;
      r_restante <= '0;
      r_causa    <= '0;
      r_pulso    <= '0;
      r_fim      <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_estado   <= w_prox;
      r_restante <= w_restante;
      r_causa    <= w_causa;
      r_pulso    <= w_pulso;
      r_fim      <= (w_prox == PULSO);
      r_ocupado  <= (w_prox != OCIOSO);
    end
  end

  assign bus.FIM      = r_fim;
  assign bus.ocupado  = r_ocupado;
  assign bus.causa    = r_causa;
  assign bus.restante = r_restante;

endmodule : temporizador_fim

// File: tb/tb_temporizador_fim.sv
// ---------------------------------------------------------------------------
// tb_temporizador_fim
// Directed bench for temporizador_fim. Three instances share one stimulus:
//   u_r0 : RETRIG=0, LARG_PULSO=1
//   u_r1 : RETRIG=1, LARG_PULSO=1
//   u_p3 : RETRIG=0, LARG_PULSO=3
// Expected values are written by hand from the timer's behaviour.
// ---------------------------------------------------------------------------
module tb_temporizador_fim;
  import maquina_pkg::*;

  localparam int ATRASO   = 4;
  localparam int LARG_CNT = $clog2(ATRASO + 1);

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tick    = 1'b0;
  logic       cancela = 1'b0;
  logic [1:0] evt     = 2'b00;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  temporizador_fim_if #(.N_EVT(2), .LARG_CNT(LARG_CNT)) if_r0 ();
  temporizador_fim_if #(.N_EVT(2), .LARG_CNT(LARG_CNT)) if_r1 ();
  temporizador_fim_if #(.N_EVT(2), .LARG_CNT(LARG_CNT)) if_p3 ();

  assign if_r0.tick = tick;  assign if_r0.evt = evt;  assign if_r0.cancela = cancela;
  assign if_r1.tick = tick;  assign if_r1.evt = evt;  assign if_r1.cancela = cancela;
  assign if_p3.tick = tick;  assign if_p3.evt = evt;  assign if_p3.cancela = cancela;

  temporizador_fim #(.N_EVT(2), .ATRASO(ATRASO), .LARG_PULSO(1), .RETRIG(1'b0))
    u_r0 (.clk(clk), .rst(rst), .bus(if_r0));
  temporizador_fim #(.N_EVT(2), .ATRASO(ATRASO), .LARG_PULSO(1), .RETRIG(1'b1))
    u_r1 (.clk(clk), .rst(rst), .bus(if_r1));
  temporizador_fim #(.N_EVT(2), .ATRASO(ATRASO), .LARG_PULSO(3), .RETRIG(1'b0))
    u_p3 (.clk(clk), .rst(rst), .bus(if_p3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  // Two idle cycles followed by a one-clk tick.
  task automatic tick_ciclo();
    repeat (2) ciclo();
    tick = 1'b1;
    ciclo();
    tick = 1'b0;
  endtask

  logic [1:0] lp, dm;

  initial begin
    lp = '0; lp[EVT_LP] = 1'b1;
    dm = '0; dm[EVT_DM] = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) ciclo();
    check("rst_fim",      if_r0.FIM,      0);
    check("rst_ocupado",  if_r0.ocupado,  0);
    check("rst_causa",    if_r0.causa,    0);
    check("rst_restante", if_r0.restante, 0);
    rst = 1'b0;
    repeat (2) ciclo();
    check("idle_ocupado", if_r0.ocupado, 0);

    // ---------------- basic timing (tick in trigger cycle ignored) -------
    evt = lp; tick = 1'b1;
    ciclo();
    tick = 1'b0;
    check("bas_ocupado",  if_r0.ocupado,  1);
    check("bas_causa",    if_r0.causa,    2'b01);
    check("bas_rest4",    if_r0.restante, 4);
    for (int i = 1; i <= 4; i++) begin
      tick_ciclo();
      if (i < 4) begin
        check("bas_rest",   if_r0.restante, 4 - i);
        check("bas_fim0",   if_r0.FIM,      0);
      end else begin
        check("bas_fim1",   if_r0.FIM,      1);
        check("bas_rest0",  if_r0.restante, 0);
        check("bas_ocp_p",  if_r0.ocupado,  1);
        check("p3_fim_c1",  if_p3.FIM,      1);
      end
    end
    ciclo();
    check("bas_fim_end",  if_r0.FIM,     0);
    check("bas_ocp_end",  if_r0.ocupado, 0);
    check("bas_cau_end",  if_r0.causa,   0);
    check("p3_fim_c2",    if_p3.FIM,     1);
    check("p3_causa_p",   if_p3.causa,   2'b01);
    ciclo();
    check("p3_fim_c3",    if_p3.FIM,     1);
    ciclo();
    check("p3_fim_end",   if_p3.FIM,     0);
    check("p3_ocp_end",   if_p3.ocupado, 0);
    evt = 2'b00;
    ciclo();

    // ---------------- simultaneous events + back-to-back ----------------
    evt = 2'b11;
    ciclo();
    check("sim_causa",    if_r0.causa,    2'b11);
    check("sim_rest",     if_r0.restante, 4);
    repeat (4) tick_ciclo();
    check("sim_fim1",     if_r0.FIM,      1);
    check("sim_causa_p",  if_r0.causa,    2'b11);
    evt = 2'b00;
    ciclo();
    check("sim_fim_end",  if_r0.FIM,      0);
    check("sim_ocp_end",  if_r0.ocupado,  0);
    evt = lp;                       // rise in first idle cycle after PULSO
    ciclo();
    check("b2b_ocupado",  if_r0.ocupado,  1);
    check("b2b_rest",     if_r0.restante, 4);
    check("b2b_causa",    if_r0.causa,    2'b01);
    cancela = 1'b1; evt = 2'b00;
    ciclo();
    cancela = 1'b0;
    check("b2b_cancel",   if_r0.ocupado,  0);
    ciclo();

    // ---------------- RETRIG=0 vs RETRIG=1, reload beats tick -----------
    evt = lp;
    ciclo();
    repeat (2) tick_ciclo();
    check("rt0_rest2",    if_r0.restante, 2);
    check("rt1_rest2",    if_r1.restante, 2);
    evt = 2'b11; tick = 1'b1;       // DM rises together with a tick
    ciclo();
    tick = 1'b0;
    check("rt0_rest1",    if_r0.restante, 1);
    check("rt0_causa",    if_r0.causa,    2'b01);
    check("rt1_reload",   if_r1.restante, 4);
    check("rt1_causa",    if_r1.causa,    2'b11);
    tick_ciclo();
    check("rt0_fim",      if_r0.FIM,      1);
    check("rt0_causa_p",  if_r0.causa,    2'b01);
    check("rt1_rest3",    if_r1.restante, 3);
    check("rt1_fim0",     if_r1.FIM,      0);
    repeat (2) tick_ciclo();
    check("rt1_rest1",    if_r1.restante, 1);
    tick_ciclo();
    check("rt1_fim",      if_r1.FIM,      1);
    check("rt1_causa_p",  if_r1.causa,    2'b11);
    evt = 2'b00;
    repeat (3) ciclo();

    // ---------------- cancel with restante=1 ----------------
    evt = lp;
    ciclo();
    repeat (3) tick_ciclo();
    check("can_rest1",    if_r0.restante, 1);
    cancela = 1'b1;
    ciclo();
    cancela = 1'b0;
    check("can_fim",      if_r0.FIM,      0);
    check("can_ocupado",  if_r0.ocupado,  0);
    check("can_causa",    if_r0.causa,    0);
    check("can_rest",     if_r0.restante, 0);
    tick_ciclo();
    check("can_nofim",    if_r0.FIM,      0);
    evt = 2'b00;
    ciclo();

    // ---------------- reset mid-PULSO, event held through reset ---------
    evt = dm;
    ciclo();
    repeat (4) tick_ciclo();
    check("rp_fim1",      if_p3.FIM,      1);
    check("rp_causa",     if_p3.causa,    2'b10);
    ciclo();
    check("rp_fim2",      if_p3.FIM,      1);
    rst = 1'b1; evt = lp;
    ciclo();
    check("rp_fim_rst",   if_p3.FIM,      0);
    check("rp_ocp_rst",   if_p3.ocupado,  0);
    check("rp_cau_rst",   if_p3.causa,    0);
    ciclo();
    check("early_in_rst", if_r0.ocupado,  0);
    rst = 1'b0;
    ciclo();
    check("early_ocp",    if_r0.ocupado,  1);
    check("early_rest",   if_r0.restante, 4);
    check("early_causa",  if_r0.causa,    2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_temporizador_fim
